// File: rtl/instr_register_pipe.sv
// Pipelined instruction register: valid/ready write port, one-stage operand capture followed by
// an ALU/write stage, DEPTH-entry result store with registered read, and a drain-then-walk clear.
module instr_register_pipe #(
    parameter int unsigned  OP_WIDTH  = 32,
    parameter int unsigned  RES_WIDTH = 64,
    parameter int unsigned  DEPTH     = 32,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [2:0]           wr_opcode,
    input  logic [OP_WIDTH-1:0]  wr_operand_a,
    input  logic [OP_WIDTH-1:0]  wr_operand_b,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic                 clear,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic                 rd_valid,
    output logic                 rd_hit,
    output logic [2:0]           rd_opcode,
    output logic [OP_WIDTH-1:0]  rd_operand_a,
    output logic [OP_WIDTH-1:0]  rd_operand_b,
    output logic [RES_WIDTH-1:0] rd_result,
    output logic                 rd_error,
    output logic                 busy,
    output logic [ADDR_W:0]      wr_count
);

    typedef enum logic [1:0] {StRun, StDrain, StClear} state_e;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [OP_WIDTH-1:0]  a;
        logic [OP_WIDTH-1:0]  b;
        logic [RES_WIDTH-1:0] result;
        logic                 error;
    } entry_t;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [2:0]            s1_opcode_q, s1_opcode_d;
    logic [OP_WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [OP_WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [ADDR_W-1:0]     s1_addr_q, s1_addr_d;
    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_W:0]       count_q, count_d;
    entry_t                rd_q, rd_d;
    logic                  rd_hit_q, rd_hit_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  accept;
    logic signed [RES_WIDTH-1:0] a_ext, b_ext, alu_res;
    logic                  alu_err;

    assign wr_ready = (state_q == StRun);
    assign busy     = (state_q != StRun);
    assign accept   = wr_valid && wr_ready;

    // Control FSM: a clear waits for the S1 stage to empty, then walks every entry once.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StRun: begin
                if (clear) state_d = StDrain;
            end
            StDrain: begin
                if (!s1_valid_q) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == LastAddr) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // S1 capture of the accepted request.
    always_comb begin
        s1_valid_d  = accept;
        s1_opcode_d = s1_opcode_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_addr_d   = s1_addr_q;
        if (accept) begin
            s1_opcode_d = wr_opcode;
            s1_a_d      = wr_operand_a;
            s1_b_d      = wr_operand_b;
            s1_addr_d   = wr_addr;
        end
    end

    // S2 ALU on sign-extended operands; RES_WIDTH > OP_WIDTH keeps MIN / -1 from overflowing.
    always_comb begin
        a_ext   = {{(RES_WIDTH - OP_WIDTH){s1_a_q[OP_WIDTH-1]}}, s1_a_q};
        b_ext   = {{(RES_WIDTH - OP_WIDTH){s1_b_q[OP_WIDTH-1]}}, s1_b_q};
        alu_res = '0;
        alu_err = 1'b0;
        case (s1_opcode_q)
            3'd0: alu_res = '0;
            3'd1: alu_res = a_ext;
            3'd2: alu_res = b_ext;
            3'd3: alu_res = a_ext + b_ext;
            3'd4: alu_res = a_ext - b_ext;
            3'd5: alu_res = a_ext * b_ext;
            3'd6: begin
                if (b_ext == '0) alu_err = 1'b1;
                else             alu_res = a_ext / b_ext;
            end
            3'd7: begin
                if (b_ext == '0) alu_err = 1'b1;
                else             alu_res = a_ext % b_ext;
            end
        endcase
    end

    // S2 array write and clear walk; they never overlap because the walk starts with S1 empty.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        count_d = count_q;
        if (s1_valid_q) begin
            mem_d[s1_addr_q] = '{opcode: s1_opcode_q, a: s1_a_q, b: s1_b_q,
                                 result: alu_res, error: alu_err};
            valid_d[s1_addr_q] = 1'b1;
            if (!valid_q[s1_addr_q]) count_d = count_q + (ADDR_W + 1)'(1);
        end
        if (state_q == StClear) begin
            mem_d[ptr_q]   = '0;
            valid_d[ptr_q] = 1'b0;
            if (ptr_q == LastAddr) count_d = '0;
        end
    end

    // Registered read port; reads the pre-write contents on a same-edge collision.
    always_comb begin
        rd_valid_d = rd_en;
        rd_d       = rd_q;
        rd_hit_d   = rd_hit_q;
        if (rd_en) begin
            rd_d     = mem_q[rd_addr];
            rd_hit_d = valid_q[rd_addr];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StRun;
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_opcode_q <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_addr_q   <= '0;
            mem_q       <= '{default: '0};
            valid_q     <= '0;
            count_q     <= '0;
            rd_q        <= '0;
            rd_hit_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_opcode_q <= s1_opcode_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_addr_q   <= s1_addr_d;
            mem_q       <= mem_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            rd_hit_q    <= rd_hit_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_hit       = rd_hit_q;
    assign rd_opcode    = rd_q.opcode;
    assign rd_operand_a = rd_q.a;
    assign rd_operand_b = rd_q.b;
    assign rd_result    = rd_q.result;
    assign rd_error     = rd_q.error;
    assign wr_count     = count_q;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Self-checking bench for instr_register_pipe with a behavioural entry-store model.
module tb_instr_register_pipe;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_opcode = '0;
    logic [31:0] wr_operand_a = '0;
    logic [31:0] wr_operand_b = '0;
    logic [AW-1:0] wr_addr = '0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic        rd_valid, rd_hit, rd_error, busy;
    logic [2:0]  rd_opcode;
    logic [31:0] rd_operand_a, rd_operand_b;
    logic [63:0] rd_result;
    logic [AW:0] wr_count;
    logic [132:0] rd_word;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference store: contents the block should hold after all accepted writes land.
    logic [2:0]  m_op  [DEPTH];
    logic [31:0] m_a   [DEPTH];
    logic [31:0] m_b   [DEPTH];
    logic [63:0] m_res [DEPTH];
    bit          m_err [DEPTH];
    bit          m_hit [DEPTH];
    int          m_count;

    always #5 clk = ~clk;

    assign rd_word = {rd_hit, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_error};

    instr_register_pipe dut (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_opcode(wr_opcode), .wr_operand_a(wr_operand_a), .wr_operand_b(wr_operand_b),
        .wr_addr(wr_addr), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_opcode(rd_opcode),
        .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b), .rd_result(rd_result),
        .rd_error(rd_error), .busy(busy), .wr_count(wr_count)
    );

    function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [63:0] r,
                                     output bit e);
        longint sa, sb;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        e  = 0;
        r  = '0;
        case (op)
            3'd0: r = 64'd0;
            3'd1: r = sa;
            3'd2: r = sb;
            3'd3: r = sa + sb;
            3'd4: r = sa - sb;
            3'd5: r = sa * sb;
            3'd6: if (sb == 0) e = 1; else r = sa / sb;
            3'd7: if (sb == 0) e = 1; else r = sa % sb;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_err[i] = 0; m_hit[i] = 0;
        end
        m_count = 0;
    endfunction

    function automatic void model_write(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int addr);
        if (!m_hit[addr]) m_count++;
        m_hit[addr] = 1;
        m_op[addr]  = op;
        m_a[addr]   = a;
        m_b[addr]   = b;
        ref_calc(op, a, b, m_res[addr], m_err[addr]);
    endfunction

    function automatic logic [132:0] exp_word(input int addr);
        return {m_hit[addr], m_op[addr], m_a[addr], m_b[addr], m_res[addr], m_err[addr]};
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    // Presents one request for one cycle; the caller guarantees the block is in RUN.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int addr);
        wr_valid     = 1'b1;
        wr_opcode    = op;
        wr_operand_a = a;
        wr_operand_b = b;
        wr_addr      = AW'(addr);
        model_write(op, a, b, addr);
        @(negedge clk);
    endtask

    task automatic rd(input int addr);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        @(negedge clk);
        rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        n_checks++;
        if ({wr_ready, busy, rd_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: got ready/busy/rvalid=%b expected 100",
                     {wr_ready, busy, rd_valid});
        end
        n_checks++;
        if (wr_count !== 6'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", wr_count);
        end
        n_checks++;
        if (rd_word !== '0) begin
            n_fail++; $display("FAIL reset_rd: got %h expected 0", rd_word);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd(i);
            n_checks++;
            if ({rd_valid, rd_word} !== {1'b1, exp_word(i)}) begin
                n_fail++;
                $display("FAIL reset_entry[%0d]: got %h expected %h", i, {rd_valid, rd_word},
                         {1'b1, exp_word(i)});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] want [3];
        want[0] = -64'sd3;
        want[1] = 64'h0000_0000_FFFF_FFFE;
        want[2] = -64'sd13;
        issue(3'd3, 32'd7, -32'sd10, 3);
        issue(3'd5, 32'h7FFF_FFFF, 32'd2, 4);
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b expected 1", wr_ready);
        end
        issue(3'd4, -32'sd5, 32'd8, 5);
        wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(3 + i);
            n_checks++;
            if (rd_word !== exp_word(3 + i) || rd_result !== want[i]) begin
                n_fail++;
                $display("FAIL b2b_entry[%0d]: got %h expected %h (result %h)", 3 + i, rd_word,
                         exp_word(3 + i), want[i]);
            end
        end
        n_checks++;
        if (wr_count !== 6'd3) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 3", wr_count);
        end
    endtask

    task automatic test_div_mod();
        logic [64:0] want [3];
        want[0] = {64'd0, 1'b1};
        want[1] = {64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        want[2] = {64'h0000_0000_8000_0000, 1'b0};
        issue(3'd6, 32'd7, 32'd0, 9);
        issue(3'd7, -32'sd7, 32'd2, 10);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 11);
        wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(9 + i);
            n_checks++;
            if (rd_word !== exp_word(9 + i) || {rd_result, rd_error} !== want[i]) begin
                n_fail++;
                $display("FAIL divmod_entry[%0d]: got %h expected %h", 9 + i, rd_word,
                         exp_word(9 + i));
            end
        end
    endtask

    task automatic test_same_edge();
        issue(3'd3, 32'd1, 32'd1, 2);
        wr_valid = 1'b0;
        rd_en    = 1'b1;
        rd_addr  = AW'(2);
        @(negedge clk);
        n_checks++;
        if ({rd_hit, rd_result} !== 65'd0) begin
            n_fail++;
            $display("FAIL same_edge_old: got hit=%b res=%h expected hit=0 res=0", rd_hit,
                     rd_result);
        end
        @(negedge clk);
        rd_en = 1'b0;
        n_checks++;
        if ({rd_hit, rd_result} !== {1'b1, 64'd2}) begin
            n_fail++;
            $display("FAIL same_edge_new: got hit=%b res=%h expected hit=1 res=2", rd_hit,
                     rd_result);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
                          int'($urandom_range(0, DEPTH - 1)));
                end else begin
                    wr_valid     = 1'b0;
                    wr_opcode    = 3'($urandom);
                    wr_operand_a = $urandom;
                    wr_addr      = AW'($urandom);
                    @(negedge clk);
                end
            end
            wr_valid = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rd(i);
                n_checks++;
                if (rd_word !== exp_word(i)) begin
                    n_fail++;
                    $display("FAIL rand_entry[%0d] round %0d: got %h expected %h", i, round,
                             rd_word, exp_word(i));
                end
            end
            n_checks++;
            if (wr_count !== (AW + 1)'(m_count)) begin
                n_fail++;
                $display("FAIL rand_count round %0d: got %0d expected %0d", round, wr_count,
                         m_count);
            end
        end
    endtask

    task automatic test_clear();
        int cyc;
        for (int i = 0; i < 4; i++) issue(3'd3, rnd_operand(), rnd_operand(), i);
        issue(3'd1, 32'h1234_5678, 32'd0, 30);
        clear = 1'b1;
        issue(3'd4, 32'd100, 32'd1, 31);
        clear = 1'b0;
        // Held request while busy must never be accepted.
        wr_valid     = 1'b1;
        wr_opcode    = 3'd1;
        wr_operand_a = 32'hDEAD_BEEF;
        wr_addr      = AW'(7);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            case (cyc)
                1: begin
                    n_checks++;
                    if (wr_ready !== 1'b0) begin
                        n_fail++; $display("FAIL clear_ready_drop: got %b expected 0", wr_ready);
                    end
                end
                5: begin rd_en = 1'b1; rd_addr = AW'(30); end
                6, 7: begin
                    n_checks++;
                    if (rd_word !== exp_word(24 + cyc)) begin
                        n_fail++;
                        $display("FAIL clear_inflight[%0d]: got %h expected %h", 24 + cyc,
                                 rd_word, exp_word(24 + cyc));
                    end
                    rd_addr = AW'(31);
                    if (cyc == 7) rd_en = 1'b0;
                end
                10: clear = 1'b1;
                11: clear = 1'b0;
                default: ;
            endcase
            @(negedge clk);
        end
        wr_valid = 1'b0;
        model_reset();
        n_checks++;
        if (cyc < 33 || cyc > 34) begin
            n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 33..34", cyc);
        end
        n_checks++;
        if ({wr_ready, wr_count} !== {1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL clear_done: got ready=%b count=%0d expected ready=1 count=0",
                     wr_ready, wr_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd(i);
            n_checks++;
            if (rd_word !== exp_word(i)) begin
                n_fail++;
                $display("FAIL clear_entry[%0d]: got %h expected %h", i, rd_word, exp_word(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) issue(3'd2, 32'd0, rnd_operand(), i);
        wr_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL midclr_busy: got %b expected 1", busy);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_ready, busy, rd_valid, wr_count, rd_word} !== {3'b100, 6'd0, 133'd0}) begin
            n_fail++;
            $display("FAIL midclr_reset: got ready/busy/rv=%b count=%0d rd=%h expected 100 0 0",
                     {wr_ready, busy, rd_valid}, wr_count, rd_word);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        issue(3'd3, 32'd5, 32'd6, 12);
        wr_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        n_checks++;
        if (wr_count !== 6'd0) begin
            n_fail++; $display("FAIL midpipe_count: got %0d expected 0", wr_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rd(12);
        n_checks++;
        if ({wr_count, rd_word} !== {6'd0, exp_word(12)}) begin
            n_fail++;
            $display("FAIL midpipe_entry: got count=%0d rd=%h expected 0 %h", wr_count, rd_word,
                     exp_word(12));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_div_mod();
        test_same_edge();
        test_random();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
